// File: rtl/memory_bus_arbiter_if.sv
// Signal bundle between the arbiter, the two pipeline stages (IF/MEM) and the shared memory bus.
// slave is the arbiter's view; master is the view of the surrounding cpu/memory.
interface memory_bus_arbiter_if;
  logic        if_request;
  logic [31:0] if_address;
  logic [31:0] if_data;
  logic        if_ready;
  logic        mem_request;
  logic        mem_write;
  logic [3:0]  mem_select;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic        bus_request;
  logic        bus_write;
  logic [3:0]  bus_select;
  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;
  logic        bus_ready;
  logic        bus_error;
  logic        stall_request;

  modport slave (
    input  if_request, if_address, mem_request, mem_write, mem_select, mem_address,
           mem_write_data, bus_read_data, bus_ready,
    output if_data, if_ready, mem_read_data, mem_ready, bus_request, bus_write,
           bus_select, bus_address, bus_write_data, bus_error, stall_request
  );

  modport master (
    output if_request, if_address, mem_request, mem_write, mem_select, mem_address,
           mem_write_data, bus_read_data, bus_ready,
    input  if_data, if_ready, mem_read_data, mem_ready, bus_request, bus_write,
           bus_select, bus_address, bus_write_data, bus_error, stall_request
  );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Shares one single-port memory bus between instruction fetch and load/store, with
// MEM priority, IF anti-starvation, bus timeout and one-cycle ready pulses.
module memory_bus_arbiter #(
  parameter int STARVE_LIMIT = 2,
  parameter int TIMEOUT      = 16
) (
  input logic                 clock,
  input logic                 reset,
  memory_bus_arbiter_if.slave bus
);
  localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int TW = (TIMEOUT < 3) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_MEM} state_t;

  state_t        r_state;
  logic [SW-1:0] r_starve;
  logic [TW-1:0] r_tmo;
  logic [31:0]   r_if_data, r_mem_read_data, r_bus_address, r_bus_write_data;
  logic [3:0]    r_bus_select;
  logic          r_if_ready, r_mem_ready, r_bus_request, r_bus_write, r_bus_error;

  logic w_quiet, w_if_win, w_grant, w_done;

  // The ready-pulse cycle never grants, so a request still held during its own pulse is not re-taken.
  assign w_quiet  = r_if_ready | r_mem_ready;
  assign w_if_win = bus.if_request & (~bus.mem_request | (r_starve == SW'(STARVE_LIMIT)));
  assign w_grant  = ~w_quiet & (w_if_win | bus.mem_request);
  assign w_done   = bus.bus_ready | (r_tmo == TW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state          <= IDLE;
      r_starve         <= '0;
      r_tmo            <= '0;
      r_if_data        <= '0;
      r_if_ready       <= 1'b0;
      r_mem_read_data  <= '0;
      r_mem_ready      <= 1'b0;
      r_bus_request    <= 1'b0;
      r_bus_write      <= 1'b0;
      r_bus_select     <= '0;
      r_bus_address    <= '0;
      r_bus_write_data <= '0;
      r_bus_error      <= 1'b0;
    end else begin
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      r_bus_error <= 1'b0;
      case (r_state)
        IDLE: if (w_grant) begin
          r_bus_request <= 1'b1;
          r_tmo         <= '0;
          if (w_if_win) begin
            r_state          <= GRANT_IF;
            r_bus_write      <= 1'b0;
            r_bus_select     <= 4'hF;
            r_bus_address    <= bus.if_address;
            r_bus_write_data <= '0;
            r_starve         <= '0;
          end else begin
            r_state          <= GRANT_MEM;
            r_bus_write      <= bus.mem_write;
            r_bus_select     <= bus.mem_select;
            r_bus_address    <= bus.mem_address;
            r_bus_write_data <= bus.mem_write_data;
            if (bus.if_request && r_starve != SW'(STARVE_LIMIT))
              r_starve <= r_starve + SW'(1);
          end
        end
        GRANT_IF, GRANT_MEM: begin
          if (w_done) begin
            r_state          <= IDLE;
            r_bus_request    <= 1'b0;
            r_bus_write      <= 1'b0;
            r_bus_select     <= '0;
            r_bus_address    <= '0;
            r_bus_write_data <= '0;
            r_bus_error      <= ~bus.bus_ready;
            if (r_state == GRANT_IF) begin
              r_if_ready <= 1'b1;
              r_if_data  <= bus.bus_ready ? bus.bus_read_data : 32'h0;
            end else begin
              r_mem_ready <= 1'b1;
              if (!bus.bus_ready)
                r_mem_read_data <= '0;
              else if (!r_bus_write)
                r_mem_read_data <= bus.bus_read_data;
            end
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.if_data        = r_if_data;
  assign bus.if_ready       = r_if_ready;
  assign bus.mem_read_data  = r_mem_read_data;
  assign bus.mem_ready      = r_mem_ready;
  assign bus.bus_request    = r_bus_request;
  assign bus.bus_write      = r_bus_write;
  assign bus.bus_select     = r_bus_select;
  assign bus.bus_address    = r_bus_address;
  assign bus.bus_write_data = r_bus_write_data;
  assign bus.bus_error      = r_bus_error;
  assign bus.stall_request  = (bus.if_request & ~r_if_ready) | (bus.mem_request & ~r_mem_ready);
endmodule
